// File: rtl/duty_ramp_controller_if.sv
// Direction type and the command handshake bundle
// shared by the duty ramp controller and its command source.
package duty_ramp_pkg;
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } rotation_direction_t;
endpackage

interface duty_ramp_if
    import duty_ramp_pkg::*;
#(
    parameter int duty_width = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_enable;
    rotation_direction_t   cmd_direction;
    logic [duty_width-1:0] cmd_duty;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_enable,
        output cmd_direction,
        output cmd_duty
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_enable,
        input  cmd_direction,
        input  cmd_duty
    );
endinterface

// File: rtl/duty_ramp_controller.sv
// Slews driver duty toward the commanded target and sequences
// direction reversals through ramp-down, coast and restart.
module duty_ramp_controller
    import duty_ramp_pkg::*;
#(
    parameter int clk_freq_hz      = 54_000_000,
    parameter int duty_width       = 10,
    parameter int counter_width    = 32,
    parameter int ramp_step_us     = 100,
    parameter int ramp_increment   = 1,
    parameter int max_duty         = 2**duty_width-1,
    parameter int stop_rpm         = 10,
    parameter int coast_timeout_ms = 500
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    duty_ramp_if.slave               cmd,
    input  logic [counter_width-1:0] rpm,
    input  logic                     hall_error,
    output logic                     enable,
    output rotation_direction_t      direction,
    output logic [duty_width-1:0]    pwm_duty,
    output logic                     at_target,
    output logic [2:0]               ramp_state
);

    localparam int STEP_CYCLES = clk_freq_hz / 1_000_000 * ramp_step_us;
    localparam longint COAST_CYCLES =
        longint'(coast_timeout_ms) * longint'(clk_freq_hz) / 1000;
    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int TW = (COAST_CYCLES > 1) ? $clog2(COAST_CYCLES) : 1;

    localparam logic [PW-1:0] STEP_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] COAST_LAST = TW'(COAST_CYCLES - 1);
    localparam logic [duty_width:0] INC = (duty_width+1)'(ramp_increment);
    localparam logic [duty_width-1:0] MAXD = duty_width'(max_duty);
    localparam logic [counter_width-1:0] STOP = counter_width'(stop_rpm);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_COAST = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [duty_width-1:0] pwm_q, pwm_d;
    rotation_direction_t   dir_q, dir_d;
    logic                  en_q, en_d;
    logic                  at_q, at_d;
    logic                  rdy_q, rdy_d;
    logic [PW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  tgt_en_q, tgt_en_d;
    rotation_direction_t   tgt_dir_q, tgt_dir_d;
    logic [duty_width-1:0] tgt_duty_q, tgt_duty_d;

    logic                  accept;
    logic [duty_width-1:0] eff;
    logic                  reversal;
    logic                  start_ok;
    logic                  step_tick;
    logic [duty_width:0]   up, dn;
    logic [duty_width-1:0] step_val;

    assign accept    = cmd.cmd_valid & rdy_q;
    assign step_tick = (cnt_q == STEP_LAST);

    always_comb begin
        tgt_en_d   = tgt_en_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_duty_d = tgt_duty_q;
        if (accept) begin
            tgt_en_d   = cmd.cmd_enable;
            tgt_dir_d  = cmd.cmd_direction;
            tgt_duty_d = (cmd.cmd_duty > MAXD) ? MAXD : cmd.cmd_duty;
        end
    end

    // Target only counts when it points the way the driver is spinning.
    always_comb begin
        eff      = '0;
        reversal = 1'b0;
        start_ok = 1'b0;
        if (tgt_en_q && tgt_dir_q != DIR_NONE) begin
            if (tgt_dir_q == dir_q) eff = tgt_duty_q;
            else reversal = 1'b1;
            start_ok = (tgt_duty_q != '0);
        end
    end

    // Wide arithmetic so a step can neither wrap nor overshoot.
    always_comb begin
        up = {1'b0, pwm_q} + INC;
        dn = {1'b0, pwm_q} - INC;
        if (pwm_q < eff) begin
            step_val = (up > {1'b0, eff}) ? eff : up[duty_width-1:0];
        end else if ({1'b0, pwm_q} < ({1'b0, eff} + INC)) begin
            step_val = eff;
        end else begin
            step_val = dn[duty_width-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        dir_d   = dir_q;
        en_d    = en_q;
        cnt_d   = '0;
        tmr_d   = '0;
        if (hall_error) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_d = S_RAMP;
                        dir_d   = tgt_dir_q;
                        en_d    = 1'b1;
                    end
                end
                S_RAMP: begin
                    cnt_d = step_tick ? '0 : cnt_q + 1'b1;
                    if (pwm_q == eff && eff != '0) begin
                        state_d = S_HOLD;
                    end else if (pwm_q == '0 && eff == '0) begin
                        state_d = reversal ? S_COAST : S_IDLE;
                    end else if (step_tick) begin
                        pwm_d = step_val;
                    end
                end
                S_HOLD: begin
                    if (eff != pwm_q) state_d = S_RAMP;
                end
                S_COAST: begin
                    tmr_d = tmr_q + 1'b1;
                    if (rpm <= STOP) begin
                        state_d = S_RAMP;
                        dir_d   = tgt_dir_q;
                        en_d    = 1'b1;
                    end else if (tmr_q == COAST_LAST) begin
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (accept && !cmd.cmd_enable) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d != state_q) begin
            cnt_d = '0;
            tmr_d = '0;
        end
        // Driver is released whenever we are not actively ramping or holding.
        if (state_d == S_IDLE || state_d == S_COAST || state_d == S_FAULT) begin
            en_d  = 1'b0;
            pwm_d = '0;
            dir_d = DIR_NONE;
        end
        at_d  = (state_d == S_HOLD);
        rdy_d = (state_d != S_COAST);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pwm_q      <= '0;
            dir_q      <= DIR_NONE;
            en_q       <= 1'b0;
            at_q       <= 1'b0;
            rdy_q      <= 1'b1;
            cnt_q      <= '0;
            tmr_q      <= '0;
            tgt_en_q   <= 1'b0;
            tgt_dir_q  <= DIR_NONE;
            tgt_duty_q <= '0;
        end else begin
            state_q    <= state_d;
            pwm_q      <= pwm_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            at_q       <= at_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            tgt_en_q   <= tgt_en_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
        end
    end

    assign enable        = en_q;
    assign direction     = dir_q;
    assign pwm_duty      = pwm_q;
    assign at_target     = at_q;
    assign ramp_state    = state_q;
    assign cmd.cmd_ready = rdy_q;

endmodule

// File: tb/tb_duty_ramp_controller.sv
// Directed bench for duty_ramp_controller: start, clamp, slew,
// reversal, coast timeout, hall fault and asynchronous reset.
module tb_duty_ramp_controller;
    import duty_ramp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rpm = 32'd0;
    logic        hall_error = 1'b0;
    logic        enable;
    rotation_direction_t direction;
    logic [9:0]  pwm_duty;
    logic        at_target;
    logic [2:0]  ramp_state;

    int errors = 0;
    int checks = 0;

    duty_ramp_if #(.duty_width(10)) cmd_if ();

    duty_ramp_controller #(
        .clk_freq_hz(1_000_000),
        .duty_width(10),
        .counter_width(32),
        .ramp_step_us(10),
        .ramp_increment(1),
        .max_duty(100),
        .stop_rpm(10),
        .coast_timeout_ms(2)
    ) dut (
        .sys_clk(clk),
        .reset_n(reset_n),
        .cmd(cmd_if),
        .rpm(rpm),
        .hall_error(hall_error),
        .enable(enable),
        .direction(direction),
        .pwm_duty(pwm_duty),
        .at_target(at_target),
        .ramp_state(ramp_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a command across one rising edge, then withdraws it.
    task automatic send(input logic en, input rotation_direction_t d,
                        input logic [9:0] duty);
        @(negedge clk);
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_enable    = en;
        cmd_if.cmd_direction = d;
        cmd_if.cmd_duty      = duty;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", ramp_state); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %0d want 0", enable); end
        checks++; if (pwm_duty !== 10'd0) begin errors++; $display("FAIL rst_pwm: got %0d want 0", pwm_duty); end
        checks++; if (direction !== DIR_NONE) begin errors++; $display("FAIL rst_dir: got %0d want 0", direction); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d want 1", cmd_if.cmd_ready); end
        checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL rst_at: got %0d want 0", at_target); end
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL rst_idle_hold: got %0d want 0", ramp_state); end
    endtask

    task automatic test_start;
        send(1'b1, DIR_CW, 10'd50);
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL start_n: got %0d want 0", ramp_state); end
        tick(1);
        checks++; if (ramp_state !== 3'd1) begin errors++; $display("FAIL start_ramp: got %0d want 1", ramp_state); end
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL start_en: got %0d want 1", enable); end
        checks++; if (direction !== DIR_CW) begin errors++; $display("FAIL start_dir: got %0d want 1", direction); end
        tick(9);
        checks++; if (pwm_duty !== 10'd0) begin errors++; $display("FAIL start_pre: got %0d want 0", pwm_duty); end
        tick(1);
        checks++; if (pwm_duty !== 10'd1) begin errors++; $display("FAIL start_step1: got %0d want 1", pwm_duty); end
        tick(490);
        checks++; if (pwm_duty !== 10'd50) begin errors++; $display("FAIL start_50: got %0d want 50", pwm_duty); end
        checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL start_at_early: got %0d want 0", at_target); end
        tick(1);
        checks++; if (ramp_state !== 3'd2) begin errors++; $display("FAIL start_hold: got %0d want 2", ramp_state); end
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL start_at: got %0d want 1", at_target); end
        send(1'b1, DIR_CW, 10'd300);
        tick(1);
        checks++; if (ramp_state !== 3'd1) begin errors++; $display("FAIL clamp_ramp: got %0d want 1", ramp_state); end
        tick(500);
        checks++; if (pwm_duty !== 10'd100) begin errors++; $display("FAIL clamp_100: got %0d want 100", pwm_duty); end
        tick(1);
        checks++; if (ramp_state !== 3'd2) begin errors++; $display("FAIL clamp_hold: got %0d want 2", ramp_state); end
        checks++; if (pwm_duty !== 10'd100) begin errors++; $display("FAIL clamp_stay: got %0d want 100", pwm_duty); end
        send(1'b1, DIR_CW, 10'd50);
        tick(501);
        checks++; if (pwm_duty !== 10'd50) begin errors++; $display("FAIL back50: got %0d want 50", pwm_duty); end
        tick(1);
    endtask

    task automatic test_slew_down;
        send(1'b1, DIR_CW, 10'd20);
        tick(1);
        checks++; if (ramp_state !== 3'd1) begin errors++; $display("FAIL slew_ramp: got %0d want 1", ramp_state); end
        tick(10);
        checks++; if (pwm_duty !== 10'd49) begin errors++; $display("FAIL slew_49: got %0d want 49", pwm_duty); end
        tick(290);
        checks++; if (pwm_duty !== 10'd20) begin errors++; $display("FAIL slew_20: got %0d want 20", pwm_duty); end
        tick(1);
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL slew_at: got %0d want 1", at_target); end
        send(1'b1, DIR_CW, 10'd50);
        tick(301);
        checks++; if (pwm_duty !== 10'd50) begin errors++; $display("FAIL slew_up50: got %0d want 50", pwm_duty); end
        tick(1);
    endtask

    task automatic test_reversal;
        rpm = 32'd100;
        send(1'b1, DIR_CCW, 10'd40);
        tick(1);
        checks++; if (direction !== DIR_CW) begin errors++; $display("FAIL rev_dir_keep: got %0d want 1", direction); end
        tick(500);
        checks++; if (pwm_duty !== 10'd0) begin errors++; $display("FAIL rev_zero: got %0d want 0", pwm_duty); end
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL rev_en_zero: got %0d want 1", enable); end
        tick(1);
        checks++; if (ramp_state !== 3'd3) begin errors++; $display("FAIL rev_coast: got %0d want 3", ramp_state); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL rev_coast_en: got %0d want 0", enable); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL rev_coast_rdy: got %0d want 0", cmd_if.cmd_ready); end
        tick(20);
        checks++; if (ramp_state !== 3'd3) begin errors++; $display("FAIL rev_still: got %0d want 3", ramp_state); end
        rpm = 32'd5;
        tick(1);
        checks++; if (ramp_state !== 3'd1) begin errors++; $display("FAIL rev_restart: got %0d want 1", ramp_state); end
        checks++; if (direction !== DIR_CCW) begin errors++; $display("FAIL rev_ccw: got %0d want 2", direction); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rev_rdy: got %0d want 1", cmd_if.cmd_ready); end
        tick(400);
        checks++; if (pwm_duty !== 10'd40) begin errors++; $display("FAIL rev_40: got %0d want 40", pwm_duty); end
        tick(1);
        checks++; if (ramp_state !== 3'd2) begin errors++; $display("FAIL rev_hold: got %0d want 2", ramp_state); end
    endtask

    task automatic test_coast_timeout;
        rpm = 32'd100;
        send(1'b1, DIR_CW, 10'd30);
        tick(401);
        checks++; if (pwm_duty !== 10'd0) begin errors++; $display("FAIL to_zero: got %0d want 0", pwm_duty); end
        tick(1);
        checks++; if (ramp_state !== 3'd3) begin errors++; $display("FAIL to_coast: got %0d want 3", ramp_state); end
        tick(1999);
        checks++; if (ramp_state !== 3'd3) begin errors++; $display("FAIL to_early: got %0d want 3", ramp_state); end
        tick(1);
        checks++; if (ramp_state !== 3'd4) begin errors++; $display("FAIL to_fault: got %0d want 4", ramp_state); end
        send(1'b0, DIR_NONE, 10'd0);
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL to_clear: got %0d want 0", ramp_state); end
        rpm = 32'd0;
    endtask

    task automatic test_hall_fault;
        send(1'b1, DIR_CW, 10'd50);
        tick(101);
        checks++; if (pwm_duty !== 10'd10) begin errors++; $display("FAIL hall_mid: got %0d want 10", pwm_duty); end
        hall_error = 1'b1;
        tick(1);
        checks++; if (ramp_state !== 3'd4) begin errors++; $display("FAIL hall_fault: got %0d want 4", ramp_state); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL hall_en: got %0d want 0", enable); end
        checks++; if (pwm_duty !== 10'd0) begin errors++; $display("FAIL hall_pwm: got %0d want 0", pwm_duty); end
        send(1'b1, DIR_CW, 10'd50);
        tick(2);
        checks++; if (ramp_state !== 3'd4) begin errors++; $display("FAIL hall_stay: got %0d want 4", ramp_state); end
        hall_error = 1'b0;
        tick(2);
        checks++; if (ramp_state !== 3'd4) begin errors++; $display("FAIL hall_stay2: got %0d want 4", ramp_state); end
        send(1'b0, DIR_NONE, 10'd0);
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL hall_clear: got %0d want 0", ramp_state); end
        tick(2);
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL hall_idle_en: got %0d want 0", enable); end
    endtask

    task automatic test_async_reset;
        send(1'b1, DIR_CW, 10'd50);
        tick(56);
        checks++; if (pwm_duty !== 10'd5) begin errors++; $display("FAIL ar_mid: got %0d want 5", pwm_duty); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL ar_state: got %0d want 0", ramp_state); end
        checks++; if (pwm_duty !== 10'd0) begin errors++; $display("FAIL ar_pwm: got %0d want 0", pwm_duty); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL ar_en: got %0d want 0", enable); end
        checks++; if (direction !== DIR_NONE) begin errors++; $display("FAIL ar_dir: got %0d want 0", direction); end
        @(negedge clk);
        reset_n = 1'b1;
        tick(5);
        checks++; if (ramp_state !== 3'd0) begin errors++; $display("FAIL ar_tgt_clr: got %0d want 0", ramp_state); end
    endtask

    initial begin
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_enable    = 1'b0;
        cmd_if.cmd_direction = DIR_NONE;
        cmd_if.cmd_duty      = 10'd0;
        test_reset();
        test_start();
        test_slew_down();
        test_reversal();
        test_coast_timeout();
        test_hall_fault();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
